// File: rtl/red_pitaya_fads_sort_seq.sv
// FADS sort sequencer: qualifies detector pulses by width, waits a flight delay,
// fires the ASG trigger plus a sort gate, then holds off for a refractory period.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a rising edge of the detector level
// MEASURE | droplet high, counting its width in cycles
// DELAY   | accepted droplet in flight towards the sort junction
// FIRE    | sort gate asserted, ASG trigger on the first cycle
// DEAD    | refractory hold-off; new droplets are counted as missed
module red_pitaya_fads_sort_seq #(
  parameter int WW = 16,
  parameter int CW = 32
) (
  input  logic          adc_clk_i,
  input  logic          adc_rstn_i,
  input  logic          sort_trig_i,
  input  logic          enable_i,
  input  logic          clear_i,
  input  logic [WW-1:0] min_width_i,
  input  logic [WW-1:0] max_width_i,
  input  logic [WW-1:0] delay_i,
  input  logic [WW-1:0] pulse_len_i,
  input  logic [WW-1:0] dead_i,
  output logic          asg_trig_o,
  output logic          sort_gate_o,
  output logic          busy_o,
  output logic [CW-1:0] droplet_cnt_o,
  output logic [CW-1:0] sorted_cnt_o,
  output logic [CW-1:0] reject_cnt_o,
  output logic [CW-1:0] missed_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEASURE,
    S_DELAY,
    S_FIRE,
    S_DEAD
  } state_t;

  localparam logic [WW-1:0] ONE = WW'(1);

  state_t        r_state;
  logic          r_trig_q;
  logic [WW-1:0] r_width;
  logic [WW-1:0] r_cnt;
  logic          r_asg;
  logic          r_gate;
  logic          r_busy;
  logic [CW-1:0] r_droplet;
  logic [CW-1:0] r_sorted;
  logic [CW-1:0] r_reject;
  logic [CW-1:0] r_missed;

  logic          w_rise;
  logic [WW-1:0] w_pulse;
  logic          w_width_ok;
  logic          w_cnt_last;
  logic          w_fall;
  logic          w_in_post;
  logic          w_ev_start;
  logic          w_ev_reject;
  logic          w_ev_fire;
  logic          w_ev_missed;

  assign w_rise     = sort_trig_i & ~r_trig_q;
  assign w_pulse    = (pulse_len_i == '0) ? ONE : pulse_len_i;
  assign w_width_ok = (r_width >= min_width_i) && (r_width <= max_width_i);
  assign w_cnt_last = (r_cnt == ONE);
  assign w_fall     = (r_state == S_MEASURE) && !sort_trig_i;
  assign w_in_post  = (r_state == S_DELAY) || (r_state == S_FIRE) || (r_state == S_DEAD);

  // Statistics events; all of them are suppressed while the sequencer is disabled.
  assign w_ev_start  = enable_i && (r_state == S_IDLE) && w_rise;
  assign w_ev_reject = enable_i && w_fall && !w_width_ok;
  assign w_ev_fire   = enable_i &&
                       ((w_fall && w_width_ok && (delay_i == '0)) ||
                        ((r_state == S_DELAY) && w_cnt_last));
  assign w_ev_missed = enable_i && w_in_post && w_rise;

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      r_state  <= S_IDLE;
      r_trig_q <= 1'b0;
      r_width  <= '0;
      r_cnt    <= '0;
      r_asg    <= 1'b0;
      r_gate   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_trig_q <= sort_trig_i;
      r_asg    <= 1'b0;
      if (!enable_i) begin
        r_state <= S_IDLE;
        r_gate  <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_rise) begin
              r_state <= S_MEASURE;
              r_width <= ONE;
              r_busy  <= 1'b1;
            end
          end
          S_MEASURE: begin
            if (sort_trig_i) begin
              if (r_width != '1) r_width <= r_width + ONE;
            end else if (!w_width_ok) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else if (delay_i == '0) begin
              r_state <= S_FIRE;
              r_cnt   <= w_pulse;
              r_gate  <= 1'b1;
              r_asg   <= 1'b1;
            end else begin
              r_state <= S_DELAY;
              r_cnt   <= delay_i;
            end
          end
          S_DELAY: begin
            if (w_cnt_last) begin
              r_state <= S_FIRE;
              r_cnt   <= w_pulse;
              r_gate  <= 1'b1;
              r_asg   <= 1'b1;
            end else begin
              r_cnt <= r_cnt - ONE;
            end
          end
          S_FIRE: begin
            if (w_cnt_last) begin
              r_gate <= 1'b0;
              if (dead_i == '0) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state <= S_DEAD;
                r_cnt   <= dead_i;
              end
            end else begin
              r_cnt <= r_cnt - ONE;
            end
          end
          S_DEAD: begin
            if (w_cnt_last) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt - ONE;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_gate  <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // A clear on the same edge as an increment takes priority.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      r_droplet <= '0;
      r_sorted  <= '0;
      r_reject  <= '0;
      r_missed  <= '0;
    end else if (clear_i) begin
      r_droplet <= '0;
      r_sorted  <= '0;
      r_reject  <= '0;
      r_missed  <= '0;
    end else begin
      if (w_ev_start)  r_droplet <= r_droplet + CW'(1);
      if (w_ev_fire)   r_sorted  <= r_sorted + CW'(1);
      if (w_ev_reject) r_reject  <= r_reject + CW'(1);
      if (w_ev_missed) r_missed  <= r_missed + CW'(1);
    end
  end

  assign asg_trig_o    = r_asg;
  assign sort_gate_o   = r_gate;
  assign busy_o        = r_busy;
  assign droplet_cnt_o = r_droplet;
  assign sorted_cnt_o  = r_sorted;
  assign reject_cnt_o  = r_reject;
  assign missed_cnt_o  = r_missed;

endmodule

// File: tb/tb_red_pitaya_fads_sort_seq.sv
// Bench for the FADS sort sequencer: directed scenarios plus randomized droplet
// trains compared against a droplet-level timeline model.
module tb_red_pitaya_fads_sort_seq;

  localparam int MAXN = 400;

  logic        clk = 1'b0;
  logic        rstn;
  logic        trig;
  logic        en;
  logic        clr;
  logic [15:0] min_w, max_w, dly, pls, ddd;
  logic        asg, gate, busy;
  logic [31:0] c_drop, c_sort, c_rej, c_miss;

  red_pitaya_fads_sort_seq #(.WW(16), .CW(32)) dut (
    .adc_clk_i    (clk),
    .adc_rstn_i   (rstn),
    .sort_trig_i  (trig),
    .enable_i     (en),
    .clear_i      (clr),
    .min_width_i  (min_w),
    .max_width_i  (max_w),
    .delay_i      (dly),
    .pulse_len_i  (pls),
    .dead_i       (ddd),
    .asg_trig_o   (asg),
    .sort_gate_o  (gate),
    .busy_o       (busy),
    .droplet_cnt_o(c_drop),
    .sorted_cnt_o (c_sort),
    .reject_cnt_o (c_rej),
    .missed_cnt_o (c_miss)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int cfg_min, cfg_max, cfg_delay, cfg_pulse, cfg_dead;

  bit s_arr[MAXN];
  bit en_arr[MAXN];
  bit clr_arr[MAXN];
  bit obs_busy[MAXN], obs_gate[MAXN], obs_asg[MAXN];
  int obs_drop[MAXN], obs_sort[MAXN];
  bit exp_busy[MAXN], exp_gate[MAXN], exp_asg[MAXN];
  int exp_drop, exp_sort, exp_rej, exp_miss;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_cfg(input int mn, input int mx, input int d, input int p, input int dd);
    cfg_min = mn; cfg_max = mx; cfg_delay = d; cfg_pulse = p; cfg_dead = dd;
    min_w = 16'(mn); max_w = 16'(mx); dly = 16'(d); pls = 16'(p); ddd = 16'(dd);
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXN; i++) begin
      s_arr[i] = 1'b0; en_arr[i] = 1'b1; clr_arr[i] = 1'b0;
    end
  endtask

  task automatic add_pulse(input int start, input int len);
    for (int i = start; i < start + len; i++)
      if (i < MAXN) s_arr[i] = 1'b1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; trig = 1'b0; en = 1'b1; clr = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Drives s_arr[k] ahead of edge k and records what the DUT shows after edge k.
  task automatic drive_trace(input int n);
    for (int k = 0; k < n; k++) begin
      trig = s_arr[k]; en = en_arr[k]; clr = clr_arr[k];
      @(posedge clk);
      @(negedge clk);
      obs_busy[k] = busy; obs_gate[k] = gate; obs_asg[k] = asg;
      obs_drop[k] = int'(c_drop); obs_sort[k] = int'(c_sort);
    end
    trig = 1'b0; en = 1'b1; clr = 1'b0;
  endtask

  // Droplet-level timeline: each measured droplet occupies a window of edges
  // [rise, decision + delay + pulse + dead); rises inside the post-decision
  // part of that window are missed, later rises start a new measurement.
  task automatic model(input int n);
    int idle_from, miss_lo, miss_hi, j, w, p, e, fin;
    bit prev, rise;
    idle_from = 0; miss_lo = 1; miss_hi = 0;
    exp_drop = 0; exp_sort = 0; exp_rej = 0; exp_miss = 0;
    for (int i = 0; i < MAXN; i++) begin
      exp_busy[i] = 1'b0; exp_gate[i] = 1'b0; exp_asg[i] = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      prev = (k == 0) ? 1'b0 : s_arr[k-1];
      rise = s_arr[k] && !prev;
      if (rise && k >= miss_lo && k <= miss_hi) begin
        exp_miss++;
      end else if (rise && k >= idle_from) begin
        exp_drop++;
        j = k + 1;
        while (j < n && s_arr[j]) j++;
        w = j - k;
        if (j >= n) begin
          for (int b = k; b < n; b++) exp_busy[b] = 1'b1;
          idle_from = n;
        end else if (w < cfg_min || w > cfg_max) begin
          exp_rej++;
          for (int b = k; b < j; b++) exp_busy[b] = 1'b1;
          idle_from = j + 1;
        end else begin
          p = (cfg_pulse == 0) ? 1 : cfg_pulse;
          e = j + cfg_delay;
          fin = e + p + cfg_dead;
          for (int b = k; b < fin && b < n; b++) exp_busy[b] = 1'b1;
          for (int b = e; b < e + p && b < n; b++) exp_gate[b] = 1'b1;
          if (e < n) begin
            exp_asg[e] = 1'b1;
            exp_sort++;
          end
          idle_from = fin + 1;
          miss_lo = j + 1;
          miss_hi = fin;
        end
      end
    end
  endtask

  task automatic test_reset();
    set_cfg(3, 10, 5, 4, 8);
    do_reset();
    n_cmp++; if ({asg, gate, busy} !== 3'b000) begin n_err++; $display("FAIL reset_outputs: got %b exp 000", {asg, gate, busy}); end
    n_cmp++; if (c_drop !== 32'd0) begin n_err++; $display("FAIL reset_droplet: got %0d exp 0", c_drop); end
    n_cmp++; if (c_sort !== 32'd0) begin n_err++; $display("FAIL reset_sorted: got %0d exp 0", c_sort); end
    n_cmp++; if (c_rej !== 32'd0) begin n_err++; $display("FAIL reset_reject: got %0d exp 0", c_rej); end
    n_cmp++; if (c_miss !== 32'd0) begin n_err++; $display("FAIL reset_missed: got %0d exp 0", c_miss); end
  endtask

  task automatic test_single_accept();
    int asg_cnt, gate_cnt, bad;
    set_cfg(3, 10, 5, 4, 8);
    do_reset();
    clear_stim();
    add_pulse(3, 6);          // falling sample at edge 9
    drive_trace(60);
    asg_cnt = 0; gate_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      asg_cnt += int'(obs_asg[k]);
      gate_cnt += int'(obs_gate[k]);
    end
    n_cmp++; if (asg_cnt != 1 || obs_asg[14] !== 1'b1) begin n_err++; $display("FAIL single_asg: count %0d at14 %b exp count 1 at14 1", asg_cnt, obs_asg[14]); end
    n_cmp++; if (gate_cnt != 4 || obs_gate[14] !== 1'b1 || obs_gate[17] !== 1'b1) begin n_err++; $display("FAIL single_gate: count %0d exp 4 starting at 14", gate_cnt); end
    n_cmp++; if (obs_busy[3] !== 1'b1 || obs_busy[2] !== 1'b0) begin n_err++; $display("FAIL single_busy_rise: got %b%b exp 01", obs_busy[2], obs_busy[3]); end
    n_cmp++; if (obs_busy[25] !== 1'b1 || obs_busy[26] !== 1'b0) begin n_err++; $display("FAIL single_busy_fall: got %b%b exp 10", obs_busy[25], obs_busy[26]); end
    n_cmp++; if (c_drop !== 32'd1 || c_sort !== 32'd1) begin n_err++; $display("FAIL single_counts: droplet %0d sorted %0d exp 1 1", c_drop, c_sort); end
    model(60);
    bad = 0;
    for (int k = 0; k < 60; k++)
      if ({obs_busy[k], obs_gate[k], obs_asg[k]} !== {exp_busy[k], exp_gate[k], exp_asg[k]}) bad++;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL single_trace: %0d cycles differ, exp 0", bad); end
  endtask

  task automatic test_width_reject();
    int gate_cnt;
    set_cfg(3, 10, 2, 3, 2);
    do_reset();
    clear_stim();
    add_pulse(3, 2);
    add_pulse(30, 11);
    drive_trace(80);
    gate_cnt = 0;
    for (int k = 0; k < 80; k++) gate_cnt += int'(obs_gate[k]) + int'(obs_asg[k]);
    n_cmp++; if (gate_cnt != 0) begin n_err++; $display("FAIL reject_no_gate: %0d gate/trig cycles exp 0", gate_cnt); end
    n_cmp++; if (obs_busy[4] !== 1'b1 || obs_busy[5] !== 1'b0) begin n_err++; $display("FAIL reject_busy_fall: got %b%b exp 10", obs_busy[4], obs_busy[5]); end
    n_cmp++; if (c_rej !== 32'd2 || c_drop !== 32'd2 || c_sort !== 32'd0) begin n_err++; $display("FAIL reject_counts: rej %0d drop %0d sort %0d exp 2 2 0", c_rej, c_drop, c_sort); end
    do_reset();
    clear_stim();
    add_pulse(3, 3);          // decision at 6, fire at 8
    add_pulse(30, 10);        // decision at 40, fire at 42
    drive_trace(80);
    n_cmp++; if (obs_asg[8] !== 1'b1 || obs_asg[42] !== 1'b1) begin n_err++; $display("FAIL boundary_fire: asg@8 %b asg@42 %b exp 1 1", obs_asg[8], obs_asg[42]); end
    n_cmp++; if (c_sort !== 32'd2 || c_rej !== 32'd0 || c_drop !== 32'd2) begin n_err++; $display("FAIL boundary_counts: sort %0d rej %0d drop %0d exp 2 0 2", c_sort, c_rej, c_drop); end
  endtask

  task automatic test_missed();
    int asg_early, bad;
    set_cfg(3, 10, 5, 4, 8);
    do_reset();
    clear_stim();
    add_pulse(3, 5);          // decision 8, fire 13, idle after 25
    add_pulse(10, 5);         // rises during DELAY
    add_pulse(19, 5);         // rises during DEAD
    add_pulse(26, 5);         // first IDLE edge: decision 31, fire 36, ends 48
    add_pulse(48, 3);         // rises exactly on the DEAD-ending edge
    drive_trace(90);
    asg_early = 0;
    for (int k = 0; k < 26; k++) asg_early += int'(obs_asg[k]);
    n_cmp++; if (asg_early != 1 || obs_asg[13] !== 1'b1) begin n_err++; $display("FAIL missed_one_fire: %0d fires before edge 26 exp 1 at 13", asg_early); end
    n_cmp++; if (obs_asg[36] !== 1'b1) begin n_err++; $display("FAIL missed_next_sorted: asg@36 %b exp 1", obs_asg[36]); end
    n_cmp++; if (obs_busy[48] !== 1'b0 || obs_busy[49] !== 1'b0) begin n_err++; $display("FAIL missed_edge_ignored: busy %b%b exp 00", obs_busy[48], obs_busy[49]); end
    n_cmp++; if (c_miss !== 32'd3 || c_drop !== 32'd2 || c_sort !== 32'd2) begin n_err++; $display("FAIL missed_counts: miss %0d drop %0d sort %0d exp 3 2 2", c_miss, c_drop, c_sort); end
    model(90);
    bad = 0;
    for (int k = 0; k < 90; k++)
      if ({obs_busy[k], obs_gate[k], obs_asg[k]} !== {exp_busy[k], exp_gate[k], exp_asg[k]}) bad++;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL missed_trace: %0d cycles differ, exp 0", bad); end
  endtask

  task automatic test_zero_params();
    set_cfg(3, 10, 0, 0, 0);
    do_reset();
    clear_stim();
    add_pulse(3, 4);          // falling sample at edge 7
    drive_trace(30);
    n_cmp++; if ({obs_busy[7], obs_gate[7], obs_asg[7]} !== 3'b111) begin n_err++; $display("FAIL zero_fire: got %b exp 111", {obs_busy[7], obs_gate[7], obs_asg[7]}); end
    n_cmp++; if ({obs_busy[8], obs_gate[8], obs_asg[8]} !== 3'b000) begin n_err++; $display("FAIL zero_idle: got %b exp 000", {obs_busy[8], obs_gate[8], obs_asg[8]}); end
    n_cmp++; if (obs_gate[6] !== 1'b0 || c_sort !== 32'd1) begin n_err++; $display("FAIL zero_counts: gate@6 %b sorted %0d exp 0 1", obs_gate[6], c_sort); end
  endtask

  task automatic test_enable_drop();
    int busy_cnt;
    set_cfg(3, 10, 2, 10, 5);
    do_reset();
    clear_stim();
    add_pulse(3, 5);          // decision 8, gate from 10
    for (int k = 12; k < 60; k++) en_arr[k] = 1'b0;
    add_pulse(20, 5);
    add_pulse(35, 5);
    drive_trace(70);
    n_cmp++; if (obs_gate[10] !== 1'b1 || obs_gate[11] !== 1'b1 || obs_asg[10] !== 1'b1) begin n_err++; $display("FAIL enable_gate_start: gate %b%b asg %b exp 11 1", obs_gate[10], obs_gate[11], obs_asg[10]); end
    n_cmp++; if (obs_gate[12] !== 1'b0 || obs_busy[12] !== 1'b0) begin n_err++; $display("FAIL enable_truncate: gate %b busy %b exp 0 0", obs_gate[12], obs_busy[12]); end
    busy_cnt = 0;
    for (int k = 12; k < 70; k++) busy_cnt += int'(obs_busy[k]) + int'(obs_gate[k]);
    n_cmp++; if (busy_cnt != 0) begin n_err++; $display("FAIL enable_ignored: %0d active cycles exp 0", busy_cnt); end
    n_cmp++; if (c_drop !== 32'd1 || c_sort !== 32'd1 || c_rej !== 32'd0 || c_miss !== 32'd0) begin n_err++; $display("FAIL enable_counts: %0d %0d %0d %0d exp 1 1 0 0", c_drop, c_sort, c_rej, c_miss); end
  endtask

  task automatic test_reset_clear();
    set_cfg(3, 10, 20, 4, 4);
    do_reset();
    clear_stim();
    add_pulse(3, 5);          // decision 8, DELAY through edge 28
    drive_trace(15);
    n_cmp++; if (busy !== 1'b1 || c_drop !== 32'd1) begin n_err++; $display("FAIL pre_reset: busy %b drop %0d exp 1 1", busy, c_drop); end
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if ({asg, gate, busy} !== 3'b000 || c_drop !== 32'd0 || c_sort !== 32'd0 || c_rej !== 32'd0 || c_miss !== 32'd0) begin
      n_err++; $display("FAIL async_reset: out %b drop %0d sort %0d rej %0d miss %0d exp all 0", {asg, gate, busy}, c_drop, c_sort, c_rej, c_miss);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    set_cfg(3, 10, 0, 2, 0);
    clear_stim();
    add_pulse(3, 5);          // accept and fire on edge 8
    clr_arr[8] = 1'b1;
    add_pulse(20, 4);         // accept and fire on edge 24
    drive_trace(40);
    n_cmp++; if (obs_drop[7] != 1 || obs_drop[8] != 0 || obs_sort[8] != 0) begin n_err++; $display("FAIL clear_wins: drop %0d->%0d sort %0d exp 1->0 0", obs_drop[7], obs_drop[8], obs_sort[8]); end
    n_cmp++; if (obs_gate[8] !== 1'b1) begin n_err++; $display("FAIL clear_still_fires: gate %b exp 1", obs_gate[8]); end
    n_cmp++; if (c_sort !== 32'd1 || c_drop !== 32'd1) begin n_err++; $display("FAIL clear_after: sort %0d drop %0d exp 1 1", c_sort, c_drop); end
  endtask

  task automatic test_random();
    int n, pos, len, bad;
    n = 300;
    for (int it = 0; it < 8; it++) begin
      len = int'($urandom_range(6, 1));
      set_cfg(len, len + int'($urandom_range(8, 0)), int'($urandom_range(6, 0)),
              int'($urandom_range(5, 0)), int'($urandom_range(6, 0)));
      clear_stim();
      pos = 2 + int'($urandom_range(5, 0));
      while (pos < n - 90) begin
        len = int'($urandom_range(14, 1));
        add_pulse(pos, len);
        pos = pos + len + int'($urandom_range(12, 1));
      end
      do_reset();
      drive_trace(n);
      model(n);
      bad = 0;
      for (int k = 0; k < n; k++)
        if ({obs_busy[k], obs_gate[k], obs_asg[k]} !== {exp_busy[k], exp_gate[k], exp_asg[k]}) begin
          if (bad < 3) $display("FAIL rand_trace it=%0d k=%0d got bga=%b exp %b", it, k,
                                {obs_busy[k], obs_gate[k], obs_asg[k]}, {exp_busy[k], exp_gate[k], exp_asg[k]});
          bad++;
        end
      n_cmp++; if (bad != 0) n_err++;
      n_cmp++; if (c_drop !== 32'(exp_drop) || c_sort !== 32'(exp_sort) || c_rej !== 32'(exp_rej) || c_miss !== 32'(exp_miss)) begin
        n_err++;
        $display("FAIL rand_counts it=%0d got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d", it,
                 c_drop, c_sort, c_rej, c_miss, exp_drop, exp_sort, exp_rej, exp_miss);
      end
    end
  endtask

  initial begin
    rstn = 1'b0; trig = 1'b0; en = 1'b1; clr = 1'b0;
    set_cfg(3, 10, 5, 4, 8);
    test_reset();
    test_single_accept();
    test_width_reject();
    test_missed();
    test_zero_params();
    test_enable_drop();
    test_reset_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/red_pitaya_fads_sort_seq.md
# red_pitaya_fads_sort_seq

Downstream stage of the FADS threshold detector. Consumes its level-type `sort_trig` output and qualifies each droplet by pulse width. For accepted droplets it waits a programmable flight delay, then emits a one-cycle start trigger to the ASG and a sort gate of programmable length, followed by a refractory period. It also keeps droplet statistics counters for the register bank.

## Interface
- `WW`, 16: width of the width, delay, pulse and dead-time fields and timers.
- `CW`, 32: width of the statistics counters.

- `adc_clk_i`  in  1  ADC clock; single clock domain.
- `adc_rstn_i`  in  1  reset; asynchronous, active-low.
- `sort_trig_i`  in  1  detector level, high while the droplet signal is above threshold.
- `enable_i`  in  1  sequencer enable (level).
- `clear_i`  in  1  one-cycle pulse; zeroes all statistics counters.
- `min_width_i`  in  WW  minimum accepted droplet width, in cycles.
- `max_width_i`  in  WW  maximum accepted droplet width, in cycles.
- `delay_i`  in  WW  cycles from end of droplet to start of fire.
- `pulse_len_i`  in  WW  sort gate length in cycles; 0 is treated as 1.
- `dead_i`  in  WW  refractory cycles after fire.
- `asg_trig_o`  out  1  one-cycle ASG start trigger.
- `sort_gate_o`  out  1  high during fire.
- `busy_o`  out  1  high whenever state ≠ IDLE.
- `droplet_cnt_o`  out  CW  droplets measured.
- `sorted_cnt_o`  out  CW  droplets fired on.
- `reject_cnt_o`  out  CW  droplets rejected for width out of range.
- `missed_cnt_o`  out  CW  droplets arriving while in DELAY/FIRE/DEAD.

## Operation
- `sort_trig_i` is registered once. A rising edge is `trig & ~trig_q`.
- The config inputs are sampled at use and must be static while `busy_o` is high. The bench does not check behaviour when they change mid-operation.
- **IDLE**
  - Rising edge and `enable_i` high: go to MEASURE with width = 1, `droplet_cnt++`.
- **MEASURE**
  - Each high sample: width++, saturating at 2^WW−1.
  - First low sample: if `min_width_i` ≤ width ≤ `max_width_i`, go to DELAY (or directly to FIRE if `delay_i` = 0).
  - Otherwise `reject_cnt++` and go to IDLE.
- **DELAY**
  - Count `delay_i` cycles, then go to FIRE.
- **FIRE**
  - `sort_gate_o` = 1 for max(`pulse_len_i`,1) cycles; `asg_trig_o` = 1 on the first FIRE cycle only.
  - `sorted_cnt++` on FIRE entry.
  - Then go to DEAD, or to IDLE if `dead_i` = 0.
- **DEAD**
  - Count `dead_i` cycles, then go to IDLE.
- A rising edge while in DELAY, FIRE or DEAD: `missed_cnt++`; the droplet is otherwise ignored.
  - A droplet still high when the state returns to IDLE is not measured, because no new rising edge occurs.
- `enable_i` low: the next edge forces IDLE and deasserts the outputs, truncating any gate in progress.
  - Counters hold their values.
  - No new droplets are counted while disabled.
- Counters wrap modulo 2^CW.
- `clear_i` zeroes all four counters. A clear on the same edge as an increment wins, so the counter reads 0.

## Timing
- Reset: state IDLE, all outputs 0, counters 0, `trig_q` 0.
- All outputs are registered.
- Edge numbering: `sort_trig_i` is sampled high at edges 0..W−1 and first low at edge W.
  - After edge 0: `busy_o` = 1.
  - After edge W: the state has decided.
- Accepted droplet, with D = `delay_i` and P = max(`pulse_len_i`,1):
  - `asg_trig_o` and `sort_gate_o` rise in the cycle after edge W+D.
  - `sort_gate_o` stays high for exactly P cycles.
  - `busy_o` falls after edge W+D+P+`dead_i`.
- Rejected droplet: `busy_o` falls after edge W, with `reject_cnt` updated on the same edge.
- Back-to-back: a rising edge sampled on the edge where DEAD ends counts as missed. A rising edge on the following edge is measured.

## Test plan
- **Single accepted droplet.** Min 3, max 10, delay 5, pulse 4, dead 8; trig high 6 cycles. Require:
  - `asg_trig_o` high exactly 1 cycle, 5 cycles after the falling sample.
  - `sort_gate_o` high 4 cycles.
  - `busy_o` falls 17 cycles after the falling sample.
  - droplet=1, sorted=1.
- **Width rejection.** Pulses of 2 and 11 cycles with min 3, max 10. Require no gate, reject=2, droplet=2, and min/max boundary widths 3 and 10 accepted.
- **Missed droplets.** A second 5-cycle pulse arriving during DELAY and a third during DEAD. Require one fire only, missed=2; a pulse starting 1 cycle after DEAD ends is sorted.
- **Zero parameters.** delay 0, pulse 0, dead 0. Require gate and trig for 1 cycle right after the falling-sample edge, and IDLE on the next edge.
- **Enable drop mid-fire.** `enable_i` low during the 2nd gate cycle of pulse 10. Require the gate low on the next edge, `busy_o` 0, counters unchanged, and input pulses ignored while disabled.
- **Reset and clear.** Assert `adc_rstn_i` mid-DELAY. Require all outputs and counters 0 immediately (asynchronously). Then `clear_i` coincident with an accept: sorted reads 0 afterwards.
